// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers; WIDTH+1 cycles from start to result.
// No queueing: start is ignored while busy, and mthi/mtlo are only honoured when idle.
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_a;
    logic               r_neg_b;
    logic [WIDTH-1:0]   r_div;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_last;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_div0;

    // Unsigned ops have op[0]=1 and bypass magnitude conversion.
    assign w_signed = ~op[0];
    assign w_neg_a  = w_signed & opa[WIDTH-1];
    assign w_neg_b  = w_signed & opb[WIDTH-1];
    assign w_mag_a  = w_neg_a ? -opa : opa;
    assign w_mag_b  = w_neg_b ? -opb : opb;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Multiply: accumulator upper half adds the multiplicand, lower half holds the shifting multiplier.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_div} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: partial remainder on top, quotient bits shift in at the bottom.
    assign w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge       = (w_shift >= {1'b0, r_div});
    assign w_diff     = w_shift - {1'b0, r_div};
    assign w_div_next = w_ge ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                             : {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    assign w_quo  = (r_neg_a ^ r_neg_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_div0 = (r_div == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_div    <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (mthi) r_hi <= wdata;
                    if (mtlo) r_lo <= wdata;
                    if (start) begin
                        r_is_div <= op[1];
                        r_neg_a  <= w_neg_a;
                        r_neg_b  <= w_neg_b;
                        r_div    <= op[1] ? w_mag_b : w_mag_a;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod;
                    end else if (w_div0) begin
                        // Divide by zero returns the dividend unchanged in HI and all ones in LO.
                        r_hi <= r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_muldiv.sv
module tb_muldiv;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          mthi;
    logic          mtlo;
    logic [W-1:0]  wdata;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural result of one operation, returned as {hi, lo}.
    function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint    sa, sb;
        int        ia, ib;
        logic [63:0] ua, ub;
        logic [31:0] q, r;
        case (o)
            2'b00: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            2'b01: begin
                ua = {32'd0, a};
                ub = {32'd0, b};
                return ua * ub;
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                ia = a;
                ib = b;
                q = 32'(ia / ib);
                r = 32'(ia % ib);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Transaction-level model: a countdown of remaining busy cycles and a pending result.
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    int           m_rem;
    logic         m_done;
    initial begin
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; m_rem = 0; m_done = 1'b0;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                    m_done = 1'b1;
                end
            end else begin
                if (mthi) m_hi = wdata;
                if (mtlo) m_lo = wdata;
                if (start) begin
                    {p_hi, p_lo} = ref_calc(op, opa, opb);
                    m_rem = W + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({hi, lo, busy, done} !== {m_hi, m_lo, (m_rem > 0), m_done}) begin
            errors++;
            $display("FAIL cycle_compare t=%0t: got hi=%h lo=%h busy=%b done=%b, expected hi=%h lo=%h busy=%b done=%b",
                     $time, hi, lo, busy, done, m_hi, m_lo, (m_rem > 0), m_done);
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; op = 2'b00; opa = '0; opb = '0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    endtask

    // Launches an op, scrambles operands after acceptance, optionally injects a busy-time
    // mtlo plus a second start, then checks latency and the literal result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string nm,
                          input bit inject);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); opa = $urandom; opb = $urandom;
        for (int k = 0; k < 50; k++) begin
            if (inject && k == 5) begin
                mtlo = 1'b1; wdata = 32'h1; start = 1'b1; op = 2'b01; opa = 32'h3; opb = 32'h3;
            end else if (inject && k == 6) begin
                mtlo = 1'b0; start = 1'b0;
            end
            if (busy) n++;
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({nm, "_done_seen"}, 64'(got), 64'd1);
        check({nm, "_busy_cycles"}, 64'(n), 64'(W + 1));
        check({nm, "_hilo"}, {hi, lo}, {ehi, elo});
    endtask

    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nd;
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_state", {hi, lo, 30'd0, busy, done}, 64'd0);

        check("model_mult_pin", ref_calc(2'b00, 32'h7, 32'hFFFFFFFF), 64'hFFFFFFFF_FFFFFFF9);
        check("model_divu_pin", ref_calc(2'b11, 32'd100, 32'd7), {32'd2, 32'd14});

        run_op(2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, "multu", 1'b0);
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg", 1'b0);
        run_op(2'b10, 32'hFFFFFFF2, 32'h00000004, 32'hFFFFFFFE, 32'hFFFFFFFD, "div_neg", 1'b0);
        run_op(2'b11, 32'd14, 32'd4, 32'd2, 32'd3, "divu", 1'b0);
        run_op(2'b11, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, "divu_by0", 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_by0", 1'b0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf", 1'b0);

        @(posedge clk); #1;
        mthi = 1'b1; wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi_idle", {32'd0, hi}, {32'd0, 32'hA5A5A5A5});

        run_op(2'b01, 32'h00010000, 32'h00010003, 32'h00000001, 32'h00030000, "busy_ignore", 1'b1);
        count_done(40, nd);
        check("busy_ignore_single_done", 64'(nd), 64'd0);

        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; opa = 32'h1234; opb = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("reset_midrun", {hi, lo, 30'd0, busy, done}, 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        count_done(40, nd);
        check("reset_midrun_no_done", 64'(nd), 64'd0);

        for (int c = 0; c < 8000; c++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom);
            opa   = pick();
            opb   = pick();
            mthi  = ($urandom_range(0, 7) == 0);
            mtlo  = ($urandom_range(0, 7) == 0);
            wdata = $urandom;
            reset = ($urandom_range(0, 2999) != 0);
        end
        @(posedge clk); #1;
        idle_inputs();
        reset = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv.md
Name: muldiv

Overview:
Iterative multiply/divide unit in the EX stage, directly downstream of the register file. It consumes the two register read operands (rdata1, rdata2) for MULT, MULTU, DIV and DIVU, and holds the architectural HI/LO registers. It exposes a start/busy/done handshake so the hazard logic can stall MFHI/MFLO until a result is ready.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
start  input  1  launch an operation; sampled only when busy=0.
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
opa  input  WIDTH  operand A (rs, from rdata1).
opb  input  WIDTH  operand B (rt, from rdata2).
mthi  input  1  write wdata into HI (MTHI).
mtlo  input  1  write wdata into LO (MTLO).
wdata  input  WIDTH  data for mthi/mtlo.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle pulse: hi/lo were just updated by a completed operation.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - hi=0, lo=0, busy=0, done=0; internal counter and accumulators cleared.
  - A reset mid-operation aborts it; no result is written.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, exactly WIDTH cycles.
  - FIX: busy=1, one cycle.
- IDLE, start=1 at edge E0:
  - Latch op.
  - Latch |opa| and |opb|. Magnitudes apply only for signed ops; unsigned ops use raw values.
  - Latch the sign flags.
  - Clear counter; go to RUN.
- RUN, one iteration per edge (E1..E32 for WIDTH=32):
  - Multiply: shift-add over a 2*WIDTH product.
  - Divide: restoring shift-subtract; remainder in the upper half, quotient in the lower half.
  - After the WIDTH-th iteration, go to FIX.
- FIX edge (E33):
  - Apply sign correction.
  - Write results:
    - Multiply: {hi,lo} = product.
    - Divide: lo = quotient, hi = remainder.
  - Set done=1; go to IDLE.
  - done clears on the next edge.
- Latency: hi/lo are valid and busy=0 in the cycle following the E33 edge, i.e. WIDTH+1 cycles after start is accepted.
- Signed rules:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend (opa).
- Divide by zero (opb=0), both DIV and DIVU:
  - lo = all ones, hi = opa.
  - Still takes full latency; no exception.
- Signed overflow, DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy=1: ignored; no queueing.
- mthi/mtlo:
  - Written at the edge only when busy=0 and the FIX edge is not occurring.
  - Ignored while busy=1.
  - mthi and mtlo together write both registers.
- start and mthi/mtlo in the same IDLE cycle: both are accepted. The mt write lands at E0; the operation result overwrites HI/LO at completion.
- Operands are latched at start; later changes on opa/opb/op have no effect.
- hi/lo hold their value at all times except the FIX edge, mt writes and reset.

Test Plan:
1. Reset low for 2 cycles, then high -> hi=0, lo=0, busy=0, done=0. Assert reset mid-RUN -> busy=0 immediately, hi/lo=0, and no done pulse follows.
2. MULTU opa=0xFFFFFFFF, opb=0x00000002 -> busy for 33 cycles, then one-cycle done; hi=0x00000001, lo=0xFFFFFFFE.
3. MULT opa=0xFFFFFFFD (-3), opb=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
4. DIV opa=0xFFFFFFF2 (-14), opb=0x00000004 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2). DIVU opa=14, opb=4 -> lo=3, hi=2.
5. DIVU opa=0x12345678, opb=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
6. MTHI wdata=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next cycle. During busy: MTLO wdata=0x1 ignored, and a second start ignored. Final lo is the first operation's result, and exactly one done pulse occurs.
